scroll_ctrl: RTL

- Sequencer for the 7-position rotating character display.
- Holds a loaded six-character message (3-bit codes) and generates the 3-bit rotation index that drives the select of the seven 3-bit 7-to-1 muxes feeding the char decoders.
- Scrolls automatically at a programmable rate, can pause, and can single-step.
- Replaces the manual KEY-driven rotation select.

---
 rtl/scroll_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/scroll_ctrl.sv
// Rotation sequencer for the 7-position scrolling character display.
// Optional macro SCROLL_BOUNCE_EN: ping-pong motion 0..6..0 driven by an internal direction register.
module scroll_ctrl #(
  parameter int DIV   = 50000000,
  parameter int CNT_W = 26
) (
  input  logic        CLOCK_50,
  input  logic        Reset,
  input  logic        Load,
  input  logic [17:0] Msg,
  input  logic        Run,
  input  logic        Dir,
  input  logic        Step,
  input  logic [1:0]  Speed,
  output logic [2:0]  Rot,
  output logic [17:0] Chars,
  output logic        Tick,
  output logic [1:0]  State
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;

  localparam logic [CNT_W-1:0] DIV_W = CNT_W'(DIV);
  localparam logic [CNT_W-1:0] ONE_W = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_W = CNT_W'(0);

  logic [1:0]       state_r, state_nxt_s;
  logic [2:0]       rot_r, rot_nxt_s, rot_adv_s;
  logic [17:0]      chars_r, chars_nxt_s;
  logic             tick_r, tick_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s, limit_s;
  logic             step_q_r, rise_s, adv_s, dir_s;

  // Next rotation index; 7 is never produced.
  function automatic logic [2:0] rot_next(input logic [2:0] r, input logic d);
    logic [2:0] n;
    case (d)
      1'b0:    n = (r >= 3'd6) ? 3'd0 : r + 3'd1;
      1'b1:    n = (r == 3'd0) ? 3'd6 : r - 3'd1;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  assign rise_s    = Step & ~step_q_r;
  assign limit_s   = (DIV_W >> Speed) - ONE_W;
  assign rot_adv_s = rot_next(rot_r, dir_s);

`ifdef SCROLL_BOUNCE_EN
  logic dir_r, dir_nxt_s;

  assign dir_s = dir_r;

  // Direction register flips when an advance lands on either end of the range.
  always_comb begin
    dir_nxt_s = dir_r;
    if (Load) begin
      dir_nxt_s = Dir;
    end else if (adv_s && (rot_adv_s == 3'd6) && !dir_r) begin
      dir_nxt_s = 1'b1;
    end else if (adv_s && (rot_adv_s == 3'd0) && dir_r) begin
      dir_nxt_s = 1'b0;
    end else begin
      dir_nxt_s = dir_r;
    end
  end

  // Direction state.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      dir_r <= Dir;
    end else begin
      dir_r <= dir_nxt_s;
    end
  end
`else
  assign dir_s = Dir;
`endif

  // FSM state register.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; Load restarts from any state.
  always_comb begin
    state_nxt_s = state_r;
    if (Load) begin
      state_nxt_s = Run ? ST_RUN : ST_PAUSE;
    end else begin
      case (state_r)
        ST_IDLE:  state_nxt_s = ST_IDLE;
        ST_RUN:   state_nxt_s = Run ? ST_RUN : ST_PAUSE;
        ST_PAUSE: state_nxt_s = Run ? ST_RUN : ST_PAUSE;
        default:  state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // FSM output logic: next values of the registered outputs and the prescaler.
  always_comb begin
    rot_nxt_s   = rot_r;
    chars_nxt_s = chars_r;
    cnt_nxt_s   = cnt_r;
    tick_nxt_s  = 1'b0;
    adv_s       = 1'b0;
    if (Load) begin
      chars_nxt_s = Msg;
      rot_nxt_s   = 3'd0;
      cnt_nxt_s   = ZERO_W;
    end else begin
      case (state_r)
        ST_RUN: begin
          // A Run drop wins over a same-cycle wrap; the count is kept for resume.
          if (!Run) begin
            cnt_nxt_s = cnt_r;
          end else if (cnt_r >= limit_s) begin
            cnt_nxt_s = ZERO_W;
            adv_s     = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r + ONE_W;
          end
        end
        ST_PAUSE: begin
          if (rise_s) begin
            adv_s = 1'b1;
          end else begin
            adv_s = 1'b0;
          end
        end
        ST_IDLE: rot_nxt_s = 3'd0;
        default: rot_nxt_s = 3'd0;
      endcase
      if (adv_s) begin
        rot_nxt_s  = rot_adv_s;
        tick_nxt_s = 1'b1;
      end else begin
        tick_nxt_s = 1'b0;
      end
    end
  end

  // Output, prescaler and step-edge registers.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      rot_r    <= 3'd0;
      chars_r  <= 18'd0;
      tick_r   <= 1'b0;
      cnt_r    <= ZERO_W;
      step_q_r <= 1'b0;
    end else begin
      rot_r    <= rot_nxt_s;
      chars_r  <= chars_nxt_s;
      tick_r   <= tick_nxt_s;
      cnt_r    <= cnt_nxt_s;
      step_q_r <= Step;
    end
  end

  assign Rot   = rot_r;
  assign Chars = chars_r;
  assign Tick  = tick_r;
  assign State = state_r;

endmodule
